vga_pixel_reader: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_pixel_reader_timing_gen.sv | 95 +++++++++
 rtl/vga_pixel_reader.sv | 113 +++++++++++
 tb/tb_vga_pixel_reader.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA scan-out timing constants and pipeline types.
// Latency: none; definitions only.
// Backpressure: none; the scan-out path is free-running.
package vga_timing_pkg;

    // 640x480@60 defaults, all in pixel periods / lines
    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    localparam int H_TOT     = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOT     = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int FRAME_PIX = DEF_H_VIS * DEF_V_VIS;

    // Colour byte lanes inside the 24-bit pixel word
    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 19;
    localparam int COL_W  = 24;

    // Sync/visible bundle carried down the alignment delay line
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic vis;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

endpackage

// File: rtl/vga_pixel_reader_timing_gen.sv
// Pixel-clock divider, h/v raster counters, raw sync/visible flags and frame tick.
// Latency: raw flags are combinational from the counters; counters step once per pix_en.
// Backpressure: none; free-running raster.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = DEF_H_VIS,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_VIS   = DEF_V_VIS,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP
) (
    input  logic  clk,
    input  logic  reset,
    output logic  pix_en_o,
    output sync_t raw_o,
    output logic  frame_wrap_o,
    output logic  frame_tick_o,
    output logic  vga_clk_o
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int H_TOT_P = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT_P = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG_P = H_VIS + H_FP;
    localparam int HS_END_P = HS_BEG_P + H_SYNC;
    localparam int VS_BEG_P = V_VIS + V_FP;
    localparam int VS_END_P = VS_BEG_P + V_SYNC;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT_P - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT_P - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] V_TICK   = CNT_W'(V_VIS - 1);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(HS_BEG_P);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HS_END_P);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(VS_BEG_P);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(VS_END_P);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             pix_en, h_last, v_last;

    assign pix_en = (div_q == DIV_LAST);
    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    // Divider and raster counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Divider wraps on pix_en; h steps every pixel, v steps when h wraps
    always_comb begin
        div_d   = pix_en ? '0 : div_q + DIV_W'(1);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    // Raw raster flags in the counter domain (undelayed)
    always_comb begin
        raw_o.vis    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        raw_o.hs_n   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        raw_o.vs_n   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        frame_wrap_o = pix_en && h_last && v_last;
        frame_tick_o = pix_en && h_last && (v_cnt_q == V_TICK);
    end

    assign pix_en_o  = pix_en;
    assign vga_clk_o = (div_q < DIV_HALF);

endmodule

// File: rtl/vga_pixel_reader.sv
// VGA scan-out: raster timing, linear pixel address to the source, aligned DAC outputs.
// Latency: 2+RD_LAT pixel periods from raster counters to vga_* pins.
// Backpressure: none; the source must return pixel_data RD_LAT pix_en stages after addr.
module vga_pixel_reader
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = DEF_H_VIS,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_VIS   = DEF_V_VIS,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP,
    parameter int RD_LAT  = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    input  logic [COL_W-1:0]  pixel_data,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              vga_clk,
    output logic              frame_tick
);

    // One stage for the address register, RD_LAT for the source, one for the colour register
    localparam int DLY = 2 + RD_LAT;

    logic              pix_en, frame_wrap;
    sync_t             raw;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    sync_t [DLY-1:0]   dly_q, dly_d;
    logic [COL_W-1:0]  rgb_q, rgb_d;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .pix_en_o     (pix_en),
        .raw_o        (raw),
        .frame_wrap_o (frame_wrap),
        .frame_tick_o (frame_tick),
        .vga_clk_o    (vga_clk)
    );

    // Address counter, address register, alignment delay line and colour register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt_q <= '0;
            addr_q     <= '0;
            dly_q      <= {DLY{SYNC_IDLE}};
            rgb_q      <= '0;
        end else begin
            addr_cnt_q <= addr_cnt_d;
            addr_q     <= addr_d;
            dly_q      <= dly_d;
            rgb_q      <= rgb_d;
        end
    end

    // addr_cnt tracks the index of the current visible pixel; addr only
    // moves on visible pixels so it holds through blanking
    always_comb begin
        addr_cnt_d = addr_cnt_q;
        addr_d     = addr_q;
        if (pix_en) begin
            if (frame_wrap) begin
                addr_cnt_d = '0;
            end else if (raw.vis) begin
                addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                addr_d     = addr_cnt_q;
            end
        end
    end

    // Delay line keeps syncs in step with colour; stage RD_LAT matches the
    // pixel currently presented on pixel_data, so it gates the capture
    always_comb begin
        dly_d = dly_q;
        rgb_d = rgb_q;
        if (pix_en) begin
            dly_d = {dly_q[DLY-2:0], raw};
            rgb_d = dly_q[RD_LAT].vis ? pixel_data : '0;
        end
    end

    assign addr        = addr_q;
    assign vga_r       = rgb_q[R_LSB +: 8];
    assign vga_g       = rgb_q[G_LSB +: 8];
    assign vga_b       = rgb_q[B_LSB +: 8];
    assign vga_hs      = dly_q[DLY-1].hs_n;
    assign vga_vs      = dly_q[DLY-1].vs_n;
    assign vga_blank_n = dly_q[DLY-1].vis;
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_pixel_reader.sv
// Bench for vga_pixel_reader: four instances (full 640x480, small raster,
// small raster with a one-stage registered source, small raster at CLK_DIV=4)
// compared every clk against an arithmetic raster model.
module tb_vga_pixel_reader;

    typedef struct packed {
        int hvis; int hfp; int hsync; int hbp;
        int vvis; int vfp; int vsync; int vbp;
        int div;  int lat;
    } cfg_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_total = 0;
    int          n_bad = 0;
    int          src_mode = 0;
    logic [23:0] src_key = '0;

    logic [18:0] addr_w [4];
    logic [23:0] pd     [4];
    logic [7:0]  r_w [4], g_w [4], b_w [4];
    logic        hs_w [4], vs_w [4], bn_w [4], sn_w [4], vc_w [4], ft_w [4];
    logic [48:0] obs  [4];
    logic [23:0] src2_q;

    always #5 clk = ~clk;

    function automatic cfg_t cfg_of(input int k);
        cfg_t c;
        c = '{hvis: 8, hfp: 2, hsync: 3, hbp: 2, vvis: 4, vfp: 1, vsync: 2, vbp: 1, div: 2, lat: 0};
        case (k)
            0: c = '{hvis: 640, hfp: 16, hsync: 96, hbp: 48, vvis: 480, vfp: 10, vsync: 2, vbp: 33, div: 2, lat: 0};
            2: c.lat = 1;
            3: c.div = 4;
            default: ;
        endcase
        return c;
    endfunction

    // Pixel source content as a function of the linear index
    function automatic logic [23:0] src_fn(input int mode, input logic [23:0] key, input logic [18:0] a);
        case (mode)
            0: return {5'b0, a};
            1: return key;
            default: return {5'b0, a} ^ key;
        endcase
    endfunction

    // Expected {hs,vs,blank_n,sync_n,vga_clk,frame_tick,r,g,b,addr} after cyc clk edges since reset release
    function automatic logic [48:0] model(input cfg_t c, input longint cyc, input int mode, input logic [23:0] key);
        longint htot, vtot, fr, j, q, h, v, idx;
        logic hs, vs, vis, ft, vclk;
        logic [23:0] d;
        logic [18:0] a;
        htot = c.hvis + c.hfp + c.hsync + c.hbp;
        vtot = c.vvis + c.vfp + c.vsync + c.vbp;
        fr   = htot * vtot;
        j    = cyc / c.div;
        vclk = (cyc % c.div) < (c.div / 2);
        ft   = ((cyc % c.div) == c.div - 1) && ((j % fr) == c.vvis * htot - 1);
        // addr: index of the latest visible raster position already passed
        a = '0;
        if (j > 0) begin
            q = (j - 1) % fr;
            h = q % htot;
            v = q / htot;
            if (v >= c.vvis)      idx = c.vvis * c.hvis - 1;
            else if (h >= c.hvis) idx = v * c.hvis + c.hvis - 1;
            else                  idx = v * c.hvis + h;
            a = 19'(idx);
        end
        hs = 1'b1; vs = 1'b1; vis = 1'b0; d = '0;
        if (j >= c.lat + 2) begin
            q   = (j - c.lat - 2) % fr;
            h   = q % htot;
            v   = q / htot;
            vis = (h < c.hvis) && (v < c.vvis);
            hs  = !((h >= c.hvis + c.hfp) && (h < c.hvis + c.hfp + c.hsync));
            vs  = !((v >= c.vvis + c.vfp) && (v < c.vvis + c.vfp + c.vsync));
            if (vis) d = src_fn(mode, key, 19'(v * c.hvis + h));
        end
        return {hs, vs, vis, 1'b0, vclk, ft, d[7:0], d[15:8], d[23:16], a};
    endfunction

    vga_pixel_reader #(.CLK_DIV(2), .RD_LAT(0)) u_def (
        .clk(clk), .reset(reset), .addr(addr_w[0]), .pixel_data(pd[0]),
        .vga_r(r_w[0]), .vga_g(g_w[0]), .vga_b(b_w[0]), .vga_hs(hs_w[0]), .vga_vs(vs_w[0]),
        .vga_blank_n(bn_w[0]), .vga_sync_n(sn_w[0]), .vga_clk(vc_w[0]), .frame_tick(ft_w[0]));

    vga_pixel_reader #(.CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                       .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(0)) u_sm0 (
        .clk(clk), .reset(reset), .addr(addr_w[1]), .pixel_data(pd[1]),
        .vga_r(r_w[1]), .vga_g(g_w[1]), .vga_b(b_w[1]), .vga_hs(hs_w[1]), .vga_vs(vs_w[1]),
        .vga_blank_n(bn_w[1]), .vga_sync_n(sn_w[1]), .vga_clk(vc_w[1]), .frame_tick(ft_w[1]));

    vga_pixel_reader #(.CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                       .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(1)) u_sm1 (
        .clk(clk), .reset(reset), .addr(addr_w[2]), .pixel_data(pd[2]),
        .vga_r(r_w[2]), .vga_g(g_w[2]), .vga_b(b_w[2]), .vga_hs(hs_w[2]), .vga_vs(vs_w[2]),
        .vga_blank_n(bn_w[2]), .vga_sync_n(sn_w[2]), .vga_clk(vc_w[2]), .frame_tick(ft_w[2]));

    vga_pixel_reader #(.CLK_DIV(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                       .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(0)) u_sm4 (
        .clk(clk), .reset(reset), .addr(addr_w[3]), .pixel_data(pd[3]),
        .vga_r(r_w[3]), .vga_g(g_w[3]), .vga_b(b_w[3]), .vga_hs(hs_w[3]), .vga_vs(vs_w[3]),
        .vga_blank_n(bn_w[3]), .vga_sync_n(sn_w[3]), .vga_clk(vc_w[3]), .frame_tick(ft_w[3]));

    assign pd[0] = src_fn(src_mode, src_key, addr_w[0]);
    assign pd[1] = src_fn(src_mode, src_key, addr_w[1]);
    assign pd[3] = src_fn(src_mode, src_key, addr_w[3]);
    assign pd[2] = src2_q;

    // Registered source: samples the address once per pixel (vga_clk low marks the pix_en cycle at CLK_DIV=2)
    always @(posedge clk or posedge reset) begin
        if (reset)        src2_q <= '0;
        else if (!vc_w[2]) src2_q <= src_fn(src_mode, src_key, addr_w[2]);
    end

    for (genvar k = 0; k < 4; k++) begin : g_obs
        assign obs[k] = {hs_w[k], vs_w[k], bn_w[k], sn_w[k], vc_w[k], ft_w[k], r_w[k], g_w[k], b_w[k], addr_w[k]};
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat ($urandom_range(2, 5)) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [48:0] exp;
        int cnt;
        src_mode = 2;
        src_key  = 24'($urandom());
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (300 + $urandom_range(0, 200)) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = model(cfg_of(k), 0, src_mode, src_key);
            n_total++;
            if (obs[k] !== exp) begin
                n_bad++;
                $display("FAIL reset_values inst=%0d got=%h exp=%h", k, obs[k], exp);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (cnt < 2000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (hs_w[0] == 1'b0) break;
        end
        n_total++;
        if (cnt != 1316) begin
            n_bad++;
            $display("FAIL first_hs_fall got=%0d clk exp=1316 clk", cnt);
        end
    endtask

    task automatic test_timing();
        logic [48:0] exp;
        int hs_low = 0;
        src_mode = 2;
        src_key  = 24'($urandom());
        do_reset();
        for (longint cyc = 1; cyc <= 5000; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            exp = model(cfg_of(0), cyc, src_mode, src_key);
            n_total++;
            if (obs[0] !== exp) begin
                n_bad++;
                $display("FAIL line_timing cyc=%0d got=%h exp=%h", cyc, obs[0], exp);
                break;
            end
            if (cyc >= 1316 && cyc <= 2915 && !hs_w[0]) hs_low++;
        end
        n_total++;
        if (hs_low != 192) begin
            n_bad++;
            $display("FAIL hs_width got=%0d clk exp=192 clk", hs_low);
        end
    endtask

    task automatic test_address();
        logic [48:0] exp;
        logic [23:0] px;
        logic [23:0] max_px = '0;
        logic [23:0] first_px = '1;
        bit seen = 0;
        int ticks = 0;
        longint last_tick = -1;
        longint gap = 0;
        src_mode = 0;
        do_reset();
        for (longint cyc = 1; cyc <= 730; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            exp = model(cfg_of(1), cyc, src_mode, src_key);
            n_total++;
            if (obs[1] !== exp) begin
                n_bad++;
                $display("FAIL addr_seq cyc=%0d got=%h exp=%h", cyc, obs[1], exp);
                break;
            end
            px = {b_w[1], g_w[1], r_w[1]};
            if (bn_w[1]) begin
                if (!seen) first_px = px;
                seen = 1;
                if (px > max_px) max_px = px;
            end
            if (ft_w[1]) begin
                ticks++;
                if (last_tick >= 0) gap = cyc - last_tick;
                last_tick = cyc;
            end
        end
        n_total++;
        if (first_px !== 24'd0) begin n_bad++; $display("FAIL first_pixel got=%0d exp=0", first_px); end
        n_total++;
        if (max_px !== 24'd31) begin n_bad++; $display("FAIL last_pixel got=%0d exp=31", max_px); end
        n_total++;
        if (ticks != 3) begin n_bad++; $display("FAIL tick_count got=%0d exp=3", ticks); end
        n_total++;
        if (gap != 240) begin n_bad++; $display("FAIL frame_period got=%0d clk exp=240 clk", gap); end
    endtask

    task automatic test_colour();
        logic [48:0] exp;
        logic [23:0] keys [2];
        bit seen;
        keys[0] = 24'h00B0FF;
        keys[1] = 24'hFFFFFF;
        for (int t = 0; t < 2; t++) begin
            src_mode = 1;
            src_key  = keys[t];
            seen = 0;
            do_reset();
            for (longint cyc = 1; cyc <= 250; cyc++) begin
                @(posedge clk);
                @(negedge clk);
                exp = model(cfg_of(1), cyc, src_mode, src_key);
                n_total++;
                if (obs[1] !== exp) begin
                    n_bad++;
                    $display("FAIL colour key=%h cyc=%0d got=%h exp=%h", keys[t], cyc, obs[1], exp);
                    break;
                end
                if (bn_w[1] && !seen) begin
                    seen = 1;
                    n_total++;
                    if ({r_w[1], g_w[1], b_w[1]} !== {keys[t][7:0], keys[t][15:8], keys[t][23:16]}) begin
                        n_bad++;
                        $display("FAIL lane_map got=%h%h%h exp=%h%h%h", r_w[1], g_w[1], b_w[1],
                                 keys[t][7:0], keys[t][15:8], keys[t][23:16]);
                    end
                end
            end
            n_total++;
            if (!seen) begin n_bad++; $display("FAIL colour_visible got=none exp=visible pixel"); end
        end
    endtask

    task automatic test_rd_lat();
        logic [48:0] exp;
        src_mode = 2;
        src_key  = 24'($urandom());
        do_reset();
        for (longint cyc = 1; cyc <= 730; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            exp = model(cfg_of(2), cyc, src_mode, src_key);
            n_total++;
            if (obs[2] !== exp) begin
                n_bad++;
                $display("FAIL rd_lat1 cyc=%0d got=%h exp=%h", cyc, obs[2], exp);
                break;
            end
        end
    endtask

    task automatic test_clk_div4();
        logic [48:0] exp;
        logic prev_vc = 1'b1;
        int rises = 0;
        int ticks = 0;
        longint last_tick = -1;
        longint gap = 0;
        src_mode = 2;
        src_key  = 24'($urandom());
        do_reset();
        for (longint cyc = 1; cyc <= 1440; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            exp = model(cfg_of(3), cyc, src_mode, src_key);
            n_total++;
            if (obs[3] !== exp) begin
                n_bad++;
                $display("FAIL clk_div4 cyc=%0d got=%h exp=%h", cyc, obs[3], exp);
                break;
            end
            if (cyc <= 400 && vc_w[3] && !prev_vc) rises++;
            prev_vc = vc_w[3];
            if (ft_w[3]) begin
                ticks++;
                if (last_tick >= 0) gap = cyc - last_tick;
                last_tick = cyc;
            end
        end
        n_total++;
        if (rises != 100) begin n_bad++; $display("FAIL vga_clk_rises got=%0d exp=100", rises); end
        n_total++;
        if (ticks != 3 || gap != 480) begin
            n_bad++;
            $display("FAIL div4_frame ticks=%0d gap=%0d exp ticks=3 gap=480", ticks, gap);
        end
    endtask

    task automatic test_mid_reset();
        logic [48:0] exp;
        bit stop = 0;
        src_mode = 2;
        src_key  = 24'($urandom());
        do_reset();
        repeat ($urandom_range(100, 400)) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = model(cfg_of(k), 0, src_mode, src_key);
            n_total++;
            if (obs[k] !== exp) begin
                n_bad++;
                $display("FAIL mid_reset_async inst=%0d got=%h exp=%h", k, obs[k], exp);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (longint cyc = 1; cyc <= 300 && !stop; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                exp = model(cfg_of(k), cyc, src_mode, src_key);
                n_total++;
                if (obs[k] !== exp) begin
                    n_bad++;
                    $display("FAIL after_mid_reset inst=%0d cyc=%0d got=%h exp=%h", k, cyc, obs[k], exp);
                    stop = 1;
                    break;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_address();
        test_colour();
        test_rd_lat();
        test_clk_div4();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
